dispatch: RTL and testbench
===========================

Name: dispatch

Overview:
- Sits directly downstream of rename and consumes its registered pair `renamed_inst0`/`renamed_inst1`.
- Routes each valid instruction, in program order, to one of three issue queues: ALU, MEM or MDU.
- Tracks partial dispatch of a pair and snoops the two CDB result buses, so operands produced while a pair is held are not lost.
- Drives `dispatch_rdy` back to rename with zero-cycle latency.

Parameters:
- `TAG_WIDTH`, default uarch_pkg `TAG_WIDTH`, ROB tag width.
- `DATA_WIDTH`, default 32, operand/result width.

Ports:
- `clk` input 1: clock.
- `rst` input 1: synchronous active-high reset.
- `flush` input 1: pipeline flush, same-cycle kill.
- `renamed_inst0` input `renamed_inst_t`: older instruction from rename.
- `renamed_inst1` input `renamed_inst_t`: younger instruction from rename.
- `rename_adv` input 1: rename's pipeline register loads this cycle (rename's `rename_rdy`).
- `dispatch_rdy` output 1: current pair fully consumed; rename may advance.
- `alu_rdy` input 2: ALU queue free slots; 00=0, 01=1, 1x=2+.
- `alu_entry0`, `alu_entry1` output `renamed_inst_t`: ALU write data, entry0 older.
- `alu_we` output 2: ALU write enables {entry1, entry0}.
- `mem_rdy`, `mem_entry0`, `mem_entry1`, `mem_we`: same as ALU, for the MEM queue.
- `mdu_rdy`, `mdu_entry0`, `mdu_entry1`, `mdu_we`: same as ALU, for the MDU queue.
- `cdb0_valid` input 1, `cdb0_tag` input `TAG_WIDTH`, `cdb0_data` input `DATA_WIDTH`: result bus 0.
- `cdb1_valid` input 1, `cdb1_tag` input `TAG_WIDTH`, `cdb1_data` input `DATA_WIDTH`: result bus 1.

Behaviour:

Routing
- `is_load` or `is_store` → MEM.
- `is_muldiv` → MDU.
- Everything else, including branch and jump → ALU.
- Invalid slots (`is_valid=0`) are ignored and count as done.

In-order rule
- inst1 may dispatch only in the same cycle as inst0 or after it.
- inst0 dispatches if its queue has ≥1 slot.
- inst1 dispatches if its queue has ≥1 slot beyond the one inst0 takes this cycle. Both targeting the same queue requires `rdy`≥2.

Port packing
- A queue receiving one instruction uses port 0.
- A queue receiving two uses port0=inst0, port1=inst1.
- Unused entry outputs are don't-care; `we` bits are 0.

FSM (2-bit state register)
- FRESH: neither instruction of the held pair has been sent.
- PARTIAL: inst0 sent, inst1 pending.
- SPENT: both sent, rename has not yet advanced. No writes; `dispatch_rdy`=1.
- Transitions:
  - FRESH → PARTIAL when inst0 dispatches and valid inst1 stalls.
  - FRESH/PARTIAL → SPENT when the pair completes and `rename_adv`=0.
  - FRESH/PARTIAL → FRESH when the pair completes and `rename_adv`=1.
  - SPENT → FRESH on `rename_adv`=1.
- `dispatch_rdy` = pair complete this cycle (all valid slots done or dispatched now), or state==SPENT.
- `dispatch_rdy` is forced to 0 during `rst`.

Operand capture
- Per slot s∈{0,1} and operand rsN, a `cap_v`/`cap_data` register.
- Capture on `cdbK_valid` when `tag==rsN_tag`, `rsN_renamed=1` and `cap_v=0`.
- If both buses match, CDB0 wins.
- Output operand priority:
  1. `cap_v` → `renamed=0`, `data=cap_data`.
  2. Same-cycle CDB match → bypass: `renamed=0`, `data=cdb_data`.
  3. Otherwise pass through unchanged.
- All `cap_v` clear when the state becomes FRESH.

Flush / reset
- `rst` or `flush`: all `we`=0 in that cycle.
- Next state FRESH; all `cap_v` cleared.
- Reset outputs: all `we`=00, `dispatch_rdy`=0.

Boundary conditions
- Both slots invalid: `dispatch_rdy`=1, no writes.
- All queues `rdy`=00: `dispatch_rdy`=0, state unchanged.
- CDB tag matching a non-renamed operand: ignored.
- A pair is never written twice: in PARTIAL, inst0 `we` stays masked.

Test Plan:
- Two ALU adds, `alu_rdy`=10, `rename_adv`=1 → `alu_we`=11, `dispatch_rdy`=1, state FRESH.
- inst0 load, inst1 mul, `mem_rdy`=01, `mdu_rdy`=00 → `mem_we`=01, `dispatch_rdy`=0, PARTIAL. Next cycle `mdu_rdy`=01 → `mdu_we`=01 carrying the mul, `mem_we`=00, `dispatch_rdy`=1.
- Two ALU ops, `alu_rdy`=01 → only inst0 written on port0. Next cycle `alu_rdy`=01 → inst1 on port0 (`alu_we`=01).
- Pair completes with `rename_adv`=0 → SPENT. Hold 3 cycles: all `we`=00, `dispatch_rdy`=1. `rename_adv`=1 → FRESH.
- inst1 `rs1_renamed`=1, `rs1_tag`=7, `mdu_rdy`=00. `cdb1` tag 7 data 0xDEADBEEF in cycle 1. Cycle 3 `mdu_rdy`=01 → `mdu_entry0.rs1_renamed`=0, `rs1_data`=0xDEADBEEF.
- In PARTIAL, assert `flush` → all `we`=00 that cycle, next state FRESH, captures cleared. `rst` mid-PARTIAL behaves identically.

Source files
------------

// File: rtl/dispatch.sv
// Dispatch stage: routes the renamed instruction pair, in program order, into the
// ALU / MEM / MDU issue queues. It tracks partially dispatched pairs and snoops both
// CDBs so operands produced while a pair is held are not lost.

package uarch_pkg;
    parameter int TAG_WIDTH  = 5;
    parameter int DATA_WIDTH = 32;

    typedef struct packed {
        logic                  is_valid;
        logic                  is_load;
        logic                  is_store;
        logic                  is_muldiv;
        logic                  is_branch;
        logic                  is_jump;
        logic [3:0]            alu_op;
        logic [TAG_WIDTH-1:0]  rob_tag;
        logic                  rs1_renamed;
        logic [TAG_WIDTH-1:0]  rs1_tag;
        logic [DATA_WIDTH-1:0] rs1_data;
        logic                  rs2_renamed;
        logic [TAG_WIDTH-1:0]  rs2_tag;
        logic [DATA_WIDTH-1:0] rs2_data;
        logic [31:0]           imm;
    } renamed_inst_t;
endpackage

module dispatch #(
    parameter int TAG_WIDTH  = uarch_pkg::TAG_WIDTH,
    parameter int DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  uarch_pkg::renamed_inst_t  renamed_inst0,
    input  uarch_pkg::renamed_inst_t  renamed_inst1,
    input  logic                      rename_adv,
    output logic                      dispatch_rdy,
    input  logic [1:0]                alu_rdy,
    output uarch_pkg::renamed_inst_t  alu_entry0,
    output uarch_pkg::renamed_inst_t  alu_entry1,
    output logic [1:0]                alu_we,
    input  logic [1:0]                mem_rdy,
    output uarch_pkg::renamed_inst_t  mem_entry0,
    output uarch_pkg::renamed_inst_t  mem_entry1,
    output logic [1:0]                mem_we,
    input  logic [1:0]                mdu_rdy,
    output uarch_pkg::renamed_inst_t  mdu_entry0,
    output uarch_pkg::renamed_inst_t  mdu_entry1,
    output logic [1:0]                mdu_we,
    input  logic                      cdb0_valid,
    input  logic [TAG_WIDTH-1:0]      cdb0_tag,
    input  logic [DATA_WIDTH-1:0]     cdb0_data,
    input  logic                      cdb1_valid,
    input  logic [TAG_WIDTH-1:0]      cdb1_tag,
    input  logic [DATA_WIDTH-1:0]     cdb1_data
);

    typedef enum logic [1:0] {
        StFresh   = 2'd0,
        StPartial = 2'd1,
        StSpent   = 2'd2
    } state_e;

    localparam logic [1:0] QAlu = 2'd0;
    localparam logic [1:0] QMem = 2'd1;
    localparam logic [1:0] QMdu = 2'd2;

    // Queue selection for one instruction.
    function automatic logic [1:0] route(input uarch_pkg::renamed_inst_t inst);
        if (inst.is_load || inst.is_store) begin
            return QMem;
        end else if (inst.is_muldiv) begin
            return QMdu;
        end
        return QAlu;
    endfunction

    // Encoded queue readiness to a free-slot count (saturating at 2).
    function automatic logic [1:0] slots(input logic [1:0] rdy);
        return rdy[1] ? 2'd2 : {1'b0, rdy[0]};
    endfunction

    // Operand override: held capture first, then same-cycle CDB0, then CDB1.
    function automatic logic [DATA_WIDTH:0] resolve(
        input logic                  ren,
        input logic [DATA_WIDTH-1:0] data,
        input logic                  cv,
        input logic [DATA_WIDTH-1:0] cd,
        input logic                  h0,
        input logic                  h1,
        input logic [DATA_WIDTH-1:0] d0,
        input logic [DATA_WIDTH-1:0] d1
    );
        if (cv) begin
            return {1'b0, cd};
        end else if (h0) begin
            return {1'b0, d0};
        end else if (h1) begin
            return {1'b0, d1};
        end
        return {ren, data};
    endfunction

    state_e state_q, state_d;

    // Operand index i = 2*slot + (0 for rs1, 1 for rs2).
    logic [3:0]            cap_v_q, cap_v_d;
    logic [DATA_WIDTH-1:0] cap_data_q [4];
    logic [DATA_WIDTH-1:0] cap_data_d [4];

    uarch_pkg::renamed_inst_t inst_in  [2];
    uarch_pkg::renamed_inst_t inst_fix [2];

    logic                  op_ren [4];
    logic [TAG_WIDTH-1:0]  op_tag [4];
    logic [3:0]            hit0, hit1;

    logic [1:0] qsel [2];
    logic [1:0] free0, free1, need1;
    logic       pend0, pend1, disp0, disp1, complete, kill, we0, we1, clr_cap;

    assign inst_in[0] = renamed_inst0;
    assign inst_in[1] = renamed_inst1;
    assign kill       = rst || flush;

    // Gather source operand tags and detect CDB matches on renamed operands.
    always_comb begin
        hit0 = '0;
        hit1 = '0;
        for (int s = 0; s < 2; s++) begin
            op_ren[2*s]   = inst_in[s].rs1_renamed;
            op_tag[2*s]   = inst_in[s].rs1_tag;
            op_ren[2*s+1] = inst_in[s].rs2_renamed;
            op_tag[2*s+1] = inst_in[s].rs2_tag;
        end
        for (int i = 0; i < 4; i++) begin
            hit0[i] = cdb0_valid && op_ren[i] && (cdb0_tag == op_tag[i]);
            hit1[i] = cdb1_valid && op_ren[i] && (cdb1_tag == op_tag[i]);
        end
    end

    // Instructions as presented to the queues, with captured/bypassed operands applied.
    always_comb begin
        for (int s = 0; s < 2; s++) begin
            inst_fix[s] = inst_in[s];
            {inst_fix[s].rs1_renamed, inst_fix[s].rs1_data} = resolve(
                inst_in[s].rs1_renamed, inst_in[s].rs1_data, cap_v_q[2*s],
                cap_data_q[2*s], hit0[2*s], hit1[2*s], cdb0_data, cdb1_data);
            {inst_fix[s].rs2_renamed, inst_fix[s].rs2_data} = resolve(
                inst_in[s].rs2_renamed, inst_in[s].rs2_data, cap_v_q[2*s+1],
                cap_data_q[2*s+1], hit0[2*s+1], hit1[2*s+1], cdb0_data, cdb1_data);
        end
    end

    // In-order dispatch decision for the held pair.
    always_comb begin
        qsel[0] = route(inst_in[0]);
        qsel[1] = route(inst_in[1]);

        unique case (qsel[0])
            QAlu:    free0 = slots(alu_rdy);
            QMem:    free0 = slots(mem_rdy);
            QMdu:    free0 = slots(mdu_rdy);
            default: free0 = 2'd0;
        endcase
        unique case (qsel[1])
            QAlu:    free1 = slots(alu_rdy);
            QMem:    free1 = slots(mem_rdy);
            QMdu:    free1 = slots(mdu_rdy);
            default: free1 = 2'd0;
        endcase

        // inst0 is only outstanding before anything of the pair was sent.
        pend0 = inst_in[0].is_valid && (state_q == StFresh);
        pend1 = inst_in[1].is_valid && (state_q != StSpent);

        disp0 = pend0 && (free0 != 2'd0);
        // inst1 needs a second slot when sharing a queue with inst0 this cycle.
        need1 = (disp0 && (qsel[0] == qsel[1])) ? 2'd2 : 2'd1;
        disp1 = pend1 && (!pend0 || disp0) && (free1 >= need1);

        complete = (state_q != StSpent) && (!pend0 || disp0) && (!pend1 || disp1);

        we0 = disp0 && !kill;
        we1 = disp1 && !kill;

        dispatch_rdy = !rst && (complete || (state_q == StSpent));
    end

    // Port packing: a lone instruction always lands on port 0.
    always_comb begin
        alu_we     = {we0 && we1 && qsel[0] == QAlu && qsel[1] == QAlu,
                      (we0 && qsel[0] == QAlu) || (we1 && qsel[1] == QAlu)};
        mem_we     = {we0 && we1 && qsel[0] == QMem && qsel[1] == QMem,
                      (we0 && qsel[0] == QMem) || (we1 && qsel[1] == QMem)};
        mdu_we     = {we0 && we1 && qsel[0] == QMdu && qsel[1] == QMdu,
                      (we0 && qsel[0] == QMdu) || (we1 && qsel[1] == QMdu)};
        alu_entry0 = (we0 && qsel[0] == QAlu) ? inst_fix[0] : inst_fix[1];
        mem_entry0 = (we0 && qsel[0] == QMem) ? inst_fix[0] : inst_fix[1];
        mdu_entry0 = (we0 && qsel[0] == QMdu) ? inst_fix[0] : inst_fix[1];
        alu_entry1 = inst_fix[1];
        mem_entry1 = inst_fix[1];
        mdu_entry1 = inst_fix[1];
    end

    // Pair-progress FSM next state.
    always_comb begin
        state_d = state_q;
        if (kill) begin
            state_d = StFresh;
        end else begin
            unique case (state_q)
                StFresh, StPartial: begin
                    if (complete) begin
                        state_d = rename_adv ? StFresh : StSpent;
                    end else if (disp0) begin
                        state_d = StPartial;
                    end
                end
                StSpent: begin
                    if (rename_adv) begin
                        state_d = StFresh;
                    end
                end
                default: state_d = StFresh;
            endcase
        end
    end

    // Operand captures live only as long as the held pair; a new pair wipes them.
    always_comb begin
        clr_cap = kill || rename_adv || ((state_d == StFresh) && (state_q != StFresh));
        cap_v_d = cap_v_q;
        for (int i = 0; i < 4; i++) begin
            cap_data_d[i] = cap_data_q[i];
            if (clr_cap) begin
                cap_v_d[i] = 1'b0;
            end else if (!cap_v_q[i] && (hit0[i] || hit1[i])) begin
                cap_v_d[i]    = 1'b1;
                cap_data_d[i] = hit0[i] ? cdb0_data : cdb1_data;
            end
        end
    end

    // State and capture registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StFresh;
            cap_v_q <= '0;
            for (int i = 0; i < 4; i++) begin
                cap_data_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cap_v_q <= cap_v_d;
            for (int i = 0; i < 4; i++) begin
                cap_data_q[i] <= cap_data_d[i];
            end
        end
    end

endmodule

// File: tb/tb_dispatch.sv
// Directed bench for dispatch: routing, in-order partial dispatch, SPENT hold,
// CDB capture/bypass, and flush/reset behaviour.

module tb_dispatch;
    import uarch_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  rst, flush, rename_adv, dispatch_rdy;
    renamed_inst_t         i0, i1;
    logic [1:0]            alu_rdy, mem_rdy, mdu_rdy, alu_we, mem_we, mdu_we;
    renamed_inst_t         alu_e0, alu_e1, mem_e0, mem_e1, mdu_e0, mdu_e1;
    logic                  cdb0_valid, cdb1_valid;
    logic [TAG_WIDTH-1:0]  cdb0_tag, cdb1_tag;
    logic [31:0]           cdb0_data, cdb1_data;

    int n_tests = 0;
    int n_fail  = 0;
    logic done = 1'b0;

    dispatch dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .renamed_inst0 (i0),
        .renamed_inst1 (i1),
        .rename_adv    (rename_adv),
        .dispatch_rdy  (dispatch_rdy),
        .alu_rdy       (alu_rdy),
        .alu_entry0    (alu_e0),
        .alu_entry1    (alu_e1),
        .alu_we        (alu_we),
        .mem_rdy       (mem_rdy),
        .mem_entry0    (mem_e0),
        .mem_entry1    (mem_e1),
        .mem_we        (mem_we),
        .mdu_rdy       (mdu_rdy),
        .mdu_entry0    (mdu_e0),
        .mdu_entry1    (mdu_e1),
        .mdu_we        (mdu_we),
        .cdb0_valid    (cdb0_valid),
        .cdb0_tag      (cdb0_tag),
        .cdb0_data     (cdb0_data),
        .cdb1_valid    (cdb1_valid),
        .cdb1_tag      (cdb1_tag),
        .cdb1_data     (cdb1_data)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // kind: 0 alu, 1 load, 2 store, 3 muldiv, 4 branch
    function automatic renamed_inst_t mk(input logic v, input int kind,
                                         input logic [TAG_WIDTH-1:0] rob);
        renamed_inst_t r;
        r          = '0;
        r.is_valid = v;
        r.rob_tag  = rob;
        case (kind)
            1:       r.is_load   = 1'b1;
            2:       r.is_store  = 1'b1;
            3:       r.is_muldiv = 1'b1;
            4:       r.is_branch = 1'b1;
            default: r.alu_op    = 4'd1;
        endcase
        return r;
    endfunction

    // Advance one cycle; inputs are then driven at the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        if (!done) begin
            $error("FAIL timeout: stimulus did not complete");
            $finish;
        end
    end

    initial begin
        rst = 1'b1; flush = 1'b0; rename_adv = 1'b0;
        i0 = '0; i1 = '0;
        alu_rdy = 2'b00; mem_rdy = 2'b00; mdu_rdy = 2'b00;
        cdb0_valid = 1'b0; cdb0_tag = '0; cdb0_data = '0;
        cdb1_valid = 1'b0; cdb1_tag = '0; cdb1_data = '0;
        @(negedge clk);

        // Reset: no writes, not ready
        i0 = mk(1, 0, 5'd1); i1 = mk(1, 0, 5'd2); alu_rdy = 2'b10; rename_adv = 1'b1;
        #2;
        check("rst_alu_we", alu_we, 2'b00);
        check("rst_mem_we", mem_we, 2'b00);
        check("rst_mdu_we", mdu_we, 2'b00);
        check("rst_rdy", dispatch_rdy, 1'b0);
        tick();
        rst = 1'b0;
        #2;

        // Two ALU adds, two slots
        check("t1_alu_we", alu_we, 2'b11);
        check("t1_rdy", dispatch_rdy, 1'b1);
        check("t1_e0", alu_e0.rob_tag, 5'd1);
        check("t1_e1", alu_e1.rob_tag, 5'd2);
        check("t1_mem_we", mem_we, 2'b00);
        tick();

        // Load + mul, MDU full -> partial
        i0 = mk(1, 1, 5'd3); i1 = mk(1, 3, 5'd4);
        alu_rdy = 2'b00; mem_rdy = 2'b01; mdu_rdy = 2'b00; rename_adv = 1'b0;
        #2;
        check("t2_mem_we", mem_we, 2'b01);
        check("t2_mem_e0", mem_e0.rob_tag, 5'd3);
        check("t2_mdu_we", mdu_we, 2'b00);
        check("t2_rdy", dispatch_rdy, 1'b0);
        tick();
        mdu_rdy = 2'b01; rename_adv = 1'b1;
        #2;
        check("t2b_mdu_we", mdu_we, 2'b01);
        check("t2b_mdu_e0", mdu_e0.rob_tag, 5'd4);
        check("t2b_mem_we", mem_we, 2'b00);
        check("t2b_rdy", dispatch_rdy, 1'b1);
        tick();

        // Two ALU ops, one slot each cycle; complete without rename_adv -> SPENT
        i0 = mk(1, 0, 5'd5); i1 = mk(1, 0, 5'd6);
        alu_rdy = 2'b01; mem_rdy = 2'b00; mdu_rdy = 2'b00; rename_adv = 1'b0;
        #2;
        check("t3_alu_we", alu_we, 2'b01);
        check("t3_e0", alu_e0.rob_tag, 5'd5);
        check("t3_rdy", dispatch_rdy, 1'b0);
        tick();
        #2;
        check("t3b_alu_we", alu_we, 2'b01);
        check("t3b_e0", alu_e0.rob_tag, 5'd6);
        check("t3b_rdy", dispatch_rdy, 1'b1);
        tick();

        // SPENT hold
        alu_rdy = 2'b10;
        for (int k = 0; k < 3; k++) begin
            #2;
            check("t4_alu_we", alu_we, 2'b00);
            check("t4_rdy", dispatch_rdy, 1'b1);
            tick();
        end
        rename_adv = 1'b1;
        #2;
        check("t4_adv_we", alu_we, 2'b00);
        check("t4_adv_rdy", dispatch_rdy, 1'b1);
        tick();
        i0 = mk(1, 0, 5'd7); i1 = mk(1, 0, 5'd8);
        #2;
        check("t4_fresh_we", alu_we, 2'b11);
        check("t4_fresh_e1", alu_e1.rob_tag, 5'd8);
        tick();

        // CDB capture while inst1 is held
        i0 = mk(1, 0, 5'd9); i1 = mk(1, 3, 5'd10);
        i1.rs1_renamed = 1'b1; i1.rs1_tag = 5'd7;
        alu_rdy = 2'b10; mdu_rdy = 2'b00; rename_adv = 1'b0;
        #2;
        check("t5_alu_we", alu_we, 2'b01);
        check("t5_rdy", dispatch_rdy, 1'b0);
        tick();
        cdb1_valid = 1'b1; cdb1_tag = 5'd7; cdb1_data = 32'hDEADBEEF;
        #2;
        check("t5_c1_mdu_we", mdu_we, 2'b00);
        tick();
        cdb1_valid = 1'b0; cdb1_data = 32'h0;
        #2;
        check("t5_c2_mdu_we", mdu_we, 2'b00);
        check("t5_c2_alu_we", alu_we, 2'b00);
        tick();
        mdu_rdy = 2'b01; rename_adv = 1'b1;
        #2;
        check("t5_c3_mdu_we", mdu_we, 2'b01);
        check("t5_c3_ren", mdu_e0.rs1_renamed, 1'b0);
        check("t5_c3_data", mdu_e0.rs1_data, 32'hDEADBEEF);
        check("t5_c3_rdy", dispatch_rdy, 1'b1);
        tick();

        // Same-cycle bypass, CDB0 priority, non-renamed operand untouched
        i0 = mk(1, 0, 5'd11);
        i0.rs2_renamed = 1'b1; i0.rs2_tag = 5'd9;
        i0.rs1_renamed = 1'b0; i0.rs1_tag = 5'd9; i0.rs1_data = 32'h55;
        i1 = mk(0, 0, 5'd0);
        alu_rdy = 2'b01; mdu_rdy = 2'b00;
        cdb0_valid = 1'b1; cdb0_tag = 5'd9; cdb0_data = 32'h1234;
        cdb1_valid = 1'b1; cdb1_tag = 5'd9; cdb1_data = 32'h5678;
        #2;
        check("t6_alu_we", alu_we, 2'b01);
        check("t6_rs2_ren", alu_e0.rs2_renamed, 1'b0);
        check("t6_rs2_data", alu_e0.rs2_data, 32'h1234);
        check("t6_rs1_data", alu_e0.rs1_data, 32'h55);
        check("t6_rdy", dispatch_rdy, 1'b1);
        tick();
        cdb0_valid = 1'b0; cdb1_valid = 1'b0;

        // Both slots invalid
        i0 = mk(0, 0, 5'd0); i1 = mk(0, 1, 5'd0);
        alu_rdy = 2'b10; mem_rdy = 2'b10; mdu_rdy = 2'b10;
        #2;
        check("t7_rdy", dispatch_rdy, 1'b1);
        check("t7_alu_we", alu_we, 2'b00);
        check("t7_mem_we", mem_we, 2'b00);
        check("t7_mdu_we", mdu_we, 2'b00);
        tick();

        // All queues full: no progress, state stays FRESH
        i0 = mk(1, 0, 5'd12); i1 = mk(1, 0, 5'd13);
        alu_rdy = 2'b00; mem_rdy = 2'b00; mdu_rdy = 2'b00; rename_adv = 1'b0;
        #2;
        check("t8_rdy", dispatch_rdy, 1'b0);
        check("t8_alu_we", alu_we, 2'b00);
        tick();
        alu_rdy = 2'b10; rename_adv = 1'b1;
        #2;
        check("t8b_alu_we", alu_we, 2'b11);
        tick();

        // Store + branch to different queues
        i0 = mk(1, 2, 5'd14); i1 = mk(1, 4, 5'd15);
        alu_rdy = 2'b01; mem_rdy = 2'b01; mdu_rdy = 2'b00;
        #2;
        check("t9_mem_we", mem_we, 2'b01);
        check("t9_mem_e0", mem_e0.rob_tag, 5'd14);
        check("t9_alu_we", alu_we, 2'b01);
        check("t9_alu_e0", alu_e0.rob_tag, 5'd15);
        check("t9_rdy", dispatch_rdy, 1'b1);
        tick();

        // Flush in PARTIAL with a pending capture
        i0 = mk(1, 0, 5'd16); i1 = mk(1, 0, 5'd17);
        i1.rs1_renamed = 1'b1; i1.rs1_tag = 5'd4;
        alu_rdy = 2'b01; mem_rdy = 2'b00; rename_adv = 1'b0;
        cdb0_valid = 1'b1; cdb0_tag = 5'd4; cdb0_data = 32'h77;
        #2;
        check("t10_alu_we", alu_we, 2'b01);
        tick();
        cdb0_valid = 1'b0; flush = 1'b1; alu_rdy = 2'b10;
        #2;
        check("t10_flush_we", alu_we, 2'b00);
        tick();
        flush = 1'b0; rename_adv = 1'b1;
        #2;
        check("t10_post_we", alu_we, 2'b11);
        check("t10_post_ren", alu_e1.rs1_renamed, 1'b1);
        check("t10_post_data", alu_e1.rs1_data, 32'h0);
        tick();

        // Reset in PARTIAL with a pending capture
        alu_rdy = 2'b01; rename_adv = 1'b0;
        cdb0_valid = 1'b1; cdb0_tag = 5'd4; cdb0_data = 32'h88;
        #2;
        check("t11_alu_we", alu_we, 2'b01);
        tick();
        cdb0_valid = 1'b0; rst = 1'b1; alu_rdy = 2'b10;
        #2;
        check("t11_rst_we", alu_we, 2'b00);
        check("t11_rst_rdy", dispatch_rdy, 1'b0);
        tick();
        rst = 1'b0; rename_adv = 1'b1;
        #2;
        check("t11_post_we", alu_we, 2'b11);
        check("t11_post_ren", alu_e1.rs1_renamed, 1'b1);
        check("t11_post_data", alu_e1.rs1_data, 32'h0);
        tick();

        done = 1'b1;
        if (n_fail != 0) begin
            $error("[TB] %0d of %0d checks failed", n_fail, n_tests);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
